// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes and sequencer state encoding
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic is_arith(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/nibble_select.sv
// rtl/nibble_select.sv - picks one 4-bit slice of a wide vector, optionally inverted
module nibble_select #(
  parameter int NIBBLES = 4,
  parameter int IW      = 2
) (
  input  logic [4*NIBBLES-1:0] vec,
  input  logic [IW-1:0]        idx,
  input  logic                 invert,
  output logic [3:0]           nib
);

  always_comb begin
    nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) nib = vec[4*i +: 4];
    end
    if (invert) nib = ~nib;
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - runs wide ADD/SUB/AND/OR one nibble per cycle
// through an external 4-bit ALU and its registered status flags.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic [1:0]           OP,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] RESULT,
  output logic                 CARRY,
  output logic                 ZERO,
  output logic [3:0]           ALU_A,
  output logic [3:0]           ALU_B,
  output logic [1:0]           ALU_OP,
  output logic                 ALU_CIN,
  input  logic [3:0]           ALU_Y,
  input  logic                 SR_C,
  input  logic                 SR_Z
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            zacc_q, zacc_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic [3:0]      a_nib, b_nib;

  nibble_select #(.NIBBLES(NIBBLES), .IW(IW)) u_sel_a (
    .vec    (a_q),
    .idx    (idx_q),
    .invert (1'b0),
    .nib    (a_nib)
  );

  // SUB is a + ~b + 1: invert B here, the +1 enters as carry-in of nibble 0.
  nibble_select #(.NIBBLES(NIBBLES), .IW(IW)) u_sel_b (
    .vec    (b_q),
    .idx    (idx_q),
    .invert (op_q == OP_SUB),
    .nib    (b_nib)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      zacc_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      res_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      zacc_q   <= zacc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_RUN;
      S_RUN:   if (idx_q == IDX_LAST) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    zacc_d   = zacc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d    = A;
          b_d    = B;
          op_d   = OP;
          idx_d  = '0;
          zacc_d = 1'b1;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) res_d[4*i +: 4] = ALU_Y;
        end
        // SR_Z lags one cycle, so it reflects the previous nibble.
        if (idx_q != '0) zacc_d = zacc_q & SR_Z;
        if (idx_q != IDX_LAST) idx_d = idx_q + IW'(1);
      end
      S_FLUSH: begin
        zacc_d   = zacc_q & SR_Z;
        zero_d   = zacc_q & SR_Z;
        carry_d  = is_arith(op_q) ? SR_C : 1'b0;
        result_d = res_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    BUSY    = (state_q == S_RUN) || (state_q == S_FLUSH);
    DONE    = (state_q == S_DONE);
    ALU_A   = '0;
    ALU_B   = '0;
    ALU_OP  = OP_ADD;
    ALU_CIN = 1'b0;
    if (state_q == S_RUN) begin
      ALU_A  = a_nib;
      ALU_B  = b_nib;
      ALU_OP = (op_q == OP_SUB) ? OP_ADD : op_q;
      if (is_arith(op_q)) begin
        ALU_CIN = (idx_q == '0) ? (op_q == OP_SUB) : SR_C;
      end
    end
  end

  assign RESULT = result_q;
  assign CARRY  = carry_q;
  assign ZERO   = zero_q;

endmodule
